mac_inverse_divider: RTL and testbench

Sequential restoring divider that undoes the team's registered multiply-add (A*B+C): given a 2S-bit product-plus-addend and an S-bit divisor, it recovers the 2S-bit quotient and S-bit remainder. It processes one quotient bit per clock using a start/busy/done handshake. It sits downstream of the multiply-accumulate datapath, decoding its results for checking and for result reconstruction. Width S is shared with the rest of the datapath through the common parameter package.

---
 rtl/mac_inverse_divider.sv | 122 ++++++++++++
 tb/tb_mac_inverse_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mac_inverse_divider.sv
// Restoring divider recovering {quotient, remainder} from a 2S-bit multiply-add result, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN: a zero divisor skips iteration, completes early and raises div_err.
module mac_inverse_divider #(
  parameter int S = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*S-1:0] dividend,
  input  logic [S-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*S-1:0] quotient,
  output logic [S-1:0]   remainder,
  output logic           div_err
);

  localparam int CW = $clog2(2*S+1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  count;
  logic [2*S-1:0] dvd_shift;
  logic [2*S-2:0] q_shift;
  logic [S-1:0]   dvs;
  logic [S-1:0]   rem_acc;
  logic [S:0]     r_trial;
  logic [S-1:0]   r_diff;
  logic           take;
  logic           zero_hit;
  logic           zero_pend;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_hit = (divisor == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // The low S bits of the difference are exact whenever the subtraction is taken.
  always_comb begin
    r_trial = {rem_acc, dvd_shift[2*S-1]};
    take    = (r_trial >= {1'b0, dvs});
    r_diff  = r_trial[S-1:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (zero_pend)                 state_nxt = DONE;
        else if (start && !zero_hit)   state_nxt = RUN;
      end
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      dvd_shift <= '0;
      q_shift   <= '0;
      dvs       <= '0;
      rem_acc   <= '0;
      zero_pend <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero divisor waits one idle cycle with start locked out, then publishes.
          if (zero_pend) begin
            zero_pend <= 1'b0;
            quotient  <= '1;
            remainder <= dvd_shift[S-1:0];
          end else if (start) begin
            dvd_shift <= dividend;
            dvs       <= divisor;
            rem_acc   <= '0;
            q_shift   <= '0;
            count     <= CW'(2*S);
            zero_pend <= zero_hit;
          end
        end
        RUN: begin
          dvd_shift <= {dvd_shift[2*S-2:0], 1'b0};
          rem_acc   <= take ? r_diff : r_trial[S-1:0];
          q_shift   <= {q_shift[2*S-3:0], take};
          count     <= count - 1'b1;
          if (count == CW'(1)) begin
            quotient  <= {q_shift, take};
            remainder <= take ? r_diff : r_trial[S-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset)                                  div_err <= 1'b0;
    else if (state == IDLE && zero_pend)        div_err <= 1'b1;
    else if (state == RUN && count == CW'(1))   div_err <= 1'b0;
  end
`else
  assign div_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_inverse_divider.sv
// Bench for mac_inverse_divider: directed divisions checked cycle by cycle against a behavioural model.
module tb_mac_inverse_divider;
  localparam int S = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  localparam int ZLAT = ZD ? 1 : 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_err;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  mac_inverse_divider #(.S(S)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_err(div_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: one outstanding division and the values the outputs must hold.
  bit          active = 1'b0;
  bit          zfast = 1'b0;
  int          c0 = 0;
  int          lat = 0;
  int          done_cyc = -1;
  int          pulses = 0;
  logic [15:0] m_q, held_q = '0;
  logic [7:0]  m_r, held_r = '0;
  logic        m_e, held_e = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r, output logic e);
    if (b == 8'd0) begin
      q = 16'hFFFF;
      r = a[7:0];
      e = ZD;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      e = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    logic eb, ed;
    eb = active && !zfast && cyc >= c0 && cyc < c0 + 2*S;
    ed = active && cyc == c0 + lat;
    chk("busy_done_exclusive", {31'd0, busy && done}, 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, eb});
    chk("done", {31'd0, done}, {31'd0, ed});
    if (done) begin
      pulses++;
      done_cyc = cyc;
    end
    if (ed) begin
      held_q = m_q;
      held_r = m_r;
      held_e = m_e;
      active = 1'b0;
    end
    chk("quotient", {16'd0, quotient}, {16'd0, held_q});
    chk("remainder", {24'd0, remainder}, {24'd0, held_r});
    chk("div_err", {31'd0, div_err}, {31'd0, held_e});
  end

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    zfast = ZD && (b == 8'd0);
    lat   = zfast ? 1 : 2*S;
    c0    = cyc;
    model(a, b, m_q, m_r, m_e);
    active = 1'b1;
  endtask

  task automatic wait_done(input string name, input logic [15:0] eq, input logic [7:0] er, input int elat);
    for (int i = 0; i < 60 && active; i++) @(posedge clk);
    chk({name, "_completed"}, {31'd0, active}, 32'd0);
    active = 1'b0;
    #1;
    chk({name, "_latency"}, done_cyc - c0, elat);
    chk({name, "_q"}, {16'd0, quotient}, {16'd0, eq});
    chk({name, "_r"}, {24'd0, remainder}, {24'd0, er});
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_q", {16'd0, quotient}, 32'd0);
    chk("reset_r", {24'd0, remainder}, 32'd0);
    chk("reset_err", {31'd0, div_err}, 32'd0);

    launch(16'd1000, 8'd7);      wait_done("div_1000_7", 16'd142, 8'd6, 16);
    launch(16'd51254, 8'd255);   wait_done("round_trip", 16'd200, 8'd254, 16);
    launch(16'd65535, 8'd1);     wait_done("max_by_one", 16'd65535, 8'd0, 16);
    launch(16'd5, 8'd255);       wait_done("small_by_max", 16'd0, 8'd5, 16);
    launch(16'h1234, 8'd0);      wait_done("div_zero", 16'hFFFF, 8'h34, ZLAT);
    chk("div_zero_err", {31'd0, div_err}, {31'd0, ZD});

    // New operands and start during RUN must not disturb the running division.
    p0 = pulses;
    launch(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 16'd60000;
    divisor  = 8'd3;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("start_in_run", 16'd142, 8'd6, 16);
    chk("start_in_run_pulses", pulses - p0, 1);
    chk("start_in_run_err", {31'd0, div_err}, 32'd0);

    // Reset sampled at the fifth step edge aborts the division.
    launch(16'd1000, 8'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    active = 1'b0;
    held_q = '0;
    held_r = '0;
    held_e = 1'b0;
    p0 = pulses;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", {16'd0, quotient}, 32'd0);
    chk("abort_r", {24'd0, remainder}, 32'd0);
    repeat (20) @(posedge clk);
    chk("abort_no_pulse", pulses - p0, 0);
    launch(16'd51254, 8'd255);   wait_done("after_abort", 16'd200, 8'd254, 16);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 16'd999;
    divisor  = 8'd9;
    @(posedge clk);
    #1;
    start  = 1'b0;
    held_q = '0;
    held_r = '0;
    held_e = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_over_start_busy", {31'd0, busy}, 32'd0);
    launch(16'd999, 8'd9);       wait_done("post_priority", 16'd111, 8'd0, 16);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
